// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall/bubble generator and ID/EX, EX/MEM, MEM/WB destination tracker
module hazard_stall_unit #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_reg,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [2:0]           id_sr1,
  input  logic                 id_sr1_needed,
  input  logic [2:0]           id_sr2,
  input  logic                 id_sr2_needed,
  input  logic [2:0]           id_dr,
  input  logic                 id_dr_needed,
  input  logic                 id_is_load,
  output logic                 stall_pc,
  output logic                 stall_if_id,
  output logic                 bubble_id_ex,
  output logic [2:0]           ex_mem_DR,
  output logic                 ex_mem_dr_needed,
  output logic [2:0]           mem_wb_DR,
  output logic                 mem_wb_dr_needed,
  output logic [CNT_WIDTH-1:0] hazard_count
);
  localparam int BW = $clog2(LU_BUBBLES + 1);
  logic [BW-1:0]        r_bub_cnt;
  logic                 r_ide_v, r_ide_ld, r_mem_v, r_wb_v;
  logic [2:0]           r_ide_dr, r_mem_dr, r_wb_dr;
  logic [CNT_WIDTH-1:0] r_hazard_count;
  logic                 w_hz, w_active;
  assign w_hz = id_valid & r_ide_v & r_ide_ld &
                ((id_sr1_needed & (id_sr1 == r_ide_dr)) | (id_sr2_needed & (id_sr2 == r_ide_dr)));
  // flush overrides any pending or new stall
  assign w_active = !flush & ((r_bub_cnt != '0) | w_hz);
  assign stall_pc         = w_active;
  assign stall_if_id      = w_active;
  assign bubble_id_ex     = w_active;
  assign ex_mem_DR        = r_mem_dr;
  assign ex_mem_dr_needed = r_mem_v;
  assign mem_wb_DR        = r_wb_dr;
  assign mem_wb_dr_needed = r_wb_v;
  assign hazard_count     = r_hazard_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bub_cnt      <= '0;
      r_ide_v        <= 1'b0;
      r_ide_ld       <= 1'b0;
      r_ide_dr       <= '0;
      r_mem_v        <= 1'b0;
      r_mem_dr       <= '0;
      r_wb_v         <= 1'b0;
      r_wb_dr        <= '0;
      r_hazard_count <= '0;
    end else if (load_reg) begin
      r_bub_cnt <= flush ? '0 : (r_bub_cnt != '0) ? r_bub_cnt - 1'b1 : w_hz ? BW'(LU_BUBBLES - 1) : '0;
      r_wb_v    <= r_mem_v;
      r_wb_dr   <= r_mem_dr;
      r_mem_v   <= r_ide_v;
      r_mem_dr  <= r_ide_dr;
      r_ide_v   <= !(w_active | flush | !id_valid | !id_dr_needed);
      r_ide_dr  <= id_dr;
      r_ide_ld  <= id_is_load;
      if (w_active && !(&r_hazard_count))
        r_hazard_count <= r_hazard_count + 1'b1;
    end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench driving a 1-bubble and a 2-bubble unit with shared stimulus
module tb_hazard_stall_unit;
  logic clk = 0, rst_n = 0, load_reg = 0, flush = 0;
  logic id_valid = 0, id_sr1_needed = 0, id_sr2_needed = 0, id_dr_needed = 0, id_is_load = 0;
  logic [2:0] id_sr1 = 0, id_sr2 = 0, id_dr = 0;
  logic [1:0] stall_pc, stall_if_id, bubble_id_ex, ex_v, wb_v;
  logic [1:0][2:0] ex_dr, wb_dr;
  logic [2:0] cnt_a;
  logic [15:0] cnt_b;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hazard_stall_unit #(.LU_BUBBLES(1), .CNT_WIDTH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .load_reg(load_reg), .flush(flush), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_needed(id_sr1_needed), .id_sr2(id_sr2), .id_sr2_needed(id_sr2_needed),
    .id_dr(id_dr), .id_dr_needed(id_dr_needed), .id_is_load(id_is_load),
    .stall_pc(stall_pc[0]), .stall_if_id(stall_if_id[0]), .bubble_id_ex(bubble_id_ex[0]),
    .ex_mem_DR(ex_dr[0]), .ex_mem_dr_needed(ex_v[0]), .mem_wb_DR(wb_dr[0]), .mem_wb_dr_needed(wb_v[0]),
    .hazard_count(cnt_a));
  hazard_stall_unit #(.LU_BUBBLES(2), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .load_reg(load_reg), .flush(flush), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_needed(id_sr1_needed), .id_sr2(id_sr2), .id_sr2_needed(id_sr2_needed),
    .id_dr(id_dr), .id_dr_needed(id_dr_needed), .id_is_load(id_is_load),
    .stall_pc(stall_pc[1]), .stall_if_id(stall_if_id[1]), .bubble_id_ex(bubble_id_ex[1]),
    .ex_mem_DR(ex_dr[1]), .ex_mem_dr_needed(ex_v[1]), .mem_wb_DR(wb_dr[1]), .mem_wb_dr_needed(wb_v[1]),
    .hazard_count(cnt_b));
  typedef struct packed {
    logic act;
    logic exv;
    logic [2:0] exdr;
    logic wbv;
    logic [2:0] wbdr;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  // reference model: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
  logic mv [2][3];
  logic [2:0] mdr [2][3];
  logic mld [2];
  int mbub [2];
  int mcnt [2];
  int lu [2] = '{1, 2};
  int cmax [2] = '{7, 65535};
  function automatic logic f_hz(int k);
    return id_valid & mv[k][0] & mld[k] &
           ((id_sr1_needed & (id_sr1 == mdr[k][0])) | (id_sr2_needed & (id_sr2 == mdr[k][0])));
  endfunction
  function automatic logic f_act(int k);
    return !flush & ((mbub[k] != 0) | f_hz(k));
  endfunction
  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 2; k++)
      if (!rst_n) begin
        mbub[k] <= 0;
        mcnt[k] <= 0;
        mld[k] <= 0;
        for (int j = 0; j < 3; j++) begin
          mv[k][j] <= 0;
          mdr[k][j] <= 0;
        end
      end else if (load_reg) begin
        if (f_act(k) && mcnt[k] < cmax[k]) mcnt[k] <= mcnt[k] + 1;
        mbub[k] <= flush ? 0 : (mbub[k] != 0) ? mbub[k] - 1 : f_hz(k) ? lu[k] - 1 : 0;
        mv[k][2] <= mv[k][1];
        mdr[k][2] <= mdr[k][1];
        mv[k][1] <= mv[k][0];
        mdr[k][1] <= mdr[k][0];
        mv[k][0] <= id_valid & id_dr_needed & !flush & !f_act(k);
        mdr[k][0] <= id_dr;
        mld[k] <= id_is_load;
      end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] cnt(int k);
    return k == 0 ? {13'd0, cnt_a} : cnt_b;
  endfunction
  function automatic logic [13:0] ldr(input logic [2:0] d, input logic [2:0] b);
    return {1'b1, b, 1'b1, 3'd0, 1'b0, d, 1'b1, 1'b1};
  endfunction
  function automatic logic [13:0] add(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    return {1'b1, a, 1'b1, b, 1'b1, d, 1'b1, 1'b0};
  endfunction
  task automatic cyc(input logic lr, input logic fl, input logic [13:0] ins);
    exp_t e;
    @(negedge clk);
    load_reg = lr;
    flush = fl;
    {id_valid, id_sr1, id_sr1_needed, id_sr2, id_sr2_needed, id_dr, id_dr_needed, id_is_load} = ins;
    for (int k = 0; k < 2; k++) begin
      e.act = f_act(k);
      e.exv = mv[k][1];
      e.exdr = mdr[k][1];
      e.wbv = mv[k][2];
      e.wbdr = mdr[k][2];
      e.cnt = 16'(mcnt[k]);
      q.push_back(e);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e = q.pop_front();
      chk($sformatf("stall_pc%0d", k), 32'(stall_pc[k]), 32'(e.act));
      chk($sformatf("stall_if_id%0d", k), 32'(stall_if_id[k]), 32'(e.act));
      chk($sformatf("bubble_id_ex%0d", k), 32'(bubble_id_ex[k]), 32'(e.act));
      chk($sformatf("ex_v%0d", k), 32'(ex_v[k]), 32'(e.exv));
      chk($sformatf("wb_v%0d", k), 32'(wb_v[k]), 32'(e.wbv));
      if (e.exv) chk($sformatf("ex_dr%0d", k), 32'(ex_dr[k]), 32'(e.exdr));
      if (e.wbv) chk($sformatf("wb_dr%0d", k), 32'(wb_dr[k]), 32'(e.wbdr));
      chk($sformatf("cnt%0d", k), 32'(cnt(k)), 32'(e.cnt));
    end
  endtask
  task automatic chk_zero(input string t);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_stall%0d", t, k), 32'({stall_pc[k], stall_if_id[k], bubble_id_ex[k]}), 0);
      chk($sformatf("%s_ex%0d", t, k), 32'({ex_v[k], ex_dr[k]}), 0);
      chk($sformatf("%s_wb%0d", t, k), 32'({wb_v[k], wb_dr[k]}), 0);
      chk($sformatf("%s_cnt%0d", t, k), 32'(cnt(k)), 0);
    end
  endtask
  initial begin
    logic [15:0] sa, sb;
    #3 chk_zero("rst_in");
    @(negedge clk) rst_n = 1;
    #1 chk_zero("rst_out");
    cyc(1, 0, ldr(3'd2, 3'd0));
    cyc(1, 0, add(3'd3, 3'd2, 3'd1));
    chk("t1_act", 32'(stall_pc[0]), 1);
    chk("t2_act", 32'(stall_pc[1]), 1);
    cyc(0, 0, add(3'd3, 3'd2, 3'd1));
    chk("t1_act_done", 32'(stall_pc[0]), 0);
    chk("t1_ex_dr", 32'(ex_dr[0]), 2);
    chk("t1_ex_v", 32'(ex_v[0]), 1);
    chk("t1_cnt", 32'(cnt_a), 1);
    repeat (2) begin
      cyc(0, 0, add(3'd3, 3'd2, 3'd1));
      chk("t2_hold_act", 32'(stall_pc[1]), 1);
      chk("t2_hold_cnt", 32'(cnt_b), 1);
    end
    cyc(1, 0, add(3'd3, 3'd2, 3'd1));
    chk("t2_act2", 32'(bubble_id_ex[1]), 1);
    cyc(1, 0, add(3'd3, 3'd2, 3'd1));
    chk("t2_act_done", 32'(stall_pc[1]), 0);
    chk("t2_cnt", 32'(cnt_b), 2);
    cyc(1, 0, add(3'd2, 3'd0, 3'd1));
    cyc(1, 0, add(3'd3, 3'd2, 3'd2));
    cyc(1, 0, 14'd0);
    chk("t3_ex_dr_a", 32'(ex_dr[0]), 2);
    chk("t3_ex_v_a", 32'(ex_v[0]), 1);
    chk("t3_ex_dr_b", 32'(ex_dr[1]), 2);
    cyc(1, 0, 14'd0);
    chk("t3_wb_dr", 32'(wb_dr[0]), 2);
    chk("t3_wb_v", 32'(wb_v[0]), 1);
    chk("t3_ex_dr_next", 32'(ex_dr[0]), 3);
    sa = {13'd0, cnt_a};
    sb = cnt_b;
    cyc(1, 0, ldr(3'd4, 3'd0));
    cyc(1, 1, add(3'd5, 3'd4, 3'd4));
    chk("t4_act_a", 32'(stall_pc[0]), 0);
    chk("t4_act_b", 32'(stall_pc[1]), 0);
    cyc(1, 0, add(3'd5, 3'd4, 3'd4));
    chk("t4_no_hz", 32'(stall_pc[0]), 0);
    chk("t4_ex_dr", 32'(ex_dr[0]), 4);
    chk("t4_cnt_a", 32'(cnt_a), 32'(sa));
    chk("t4_cnt_b", 32'(cnt_b), 32'(sb));
    cyc(1, 0, 14'd0);
    chk("t4_ex_flushed_a", 32'(ex_v[0]), 0);
    chk("t4_ex_flushed_b", 32'(ex_v[1]), 0);
    cyc(1, 0, ldr(3'd6, 3'd0));
    cyc(1, 0, add(3'd7, 3'd6, 3'd6));
    cyc(1, 0, add(3'd7, 3'd6, 3'd6));
    chk("t6_pre", 32'(stall_pc[1]), 1);
    #2 rst_n = 0;
    #1 chk_zero("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (12) begin
      cyc(1, 0, ldr(3'd1, 3'd0));
      cyc(1, 0, add(3'd1, 3'd1, 3'd0));
    end
    chk("t5_sat", 32'(cnt_a), 7);
    repeat (2) begin
      cyc(1, 0, ldr(3'd1, 3'd0));
      cyc(1, 0, add(3'd1, 3'd1, 3'd0));
    end
    chk("t5_sat_hold", 32'(cnt_a), 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
